// File: rtl/sc_const_bank.sv
// -----------------------------------------------------------------------------
// sc_const_bank
//
// Bank of stochastic-computing constant generators. A single WIDTH-bit
// maximal-length Fibonacci LFSR (or, in counter mode, the phase counter) is
// compared against a per-channel value, so each channel emits exactly
// active_value ones in every P = 2^WIDTH-1 cycle period.
//
// New values are written into per-channel shadow registers and take effect
// together at the period boundary (or immediately on restart), so a period
// never mixes old and new values.
//
// Ports
//   clk           in   clock
//   n_rst         in   asynchronous active-low reset
//   en            in   advance the generator; low holds outputs and state
//   restart       in   synchronous period restart (overrides en)
//   mode          in   0 = LFSR (random), 1 = counter (unary); sampled at
//                      the boundary or on restart
//   wr_en         in   value write request
//   wr_addr       in   target channel
//   wr_data       in   new value (ones per period)
//   wr_ready      out  write accept (channel has no pending value)
//   out           out  registered bitstreams, one bit per channel
//   period_start  out  high on the first output bit of each period
// -----------------------------------------------------------------------------
module sc_const_bank #(
  parameter int                          CHANNELS    = 4,
  parameter int                          WIDTH       = 9,
  parameter int                          SEED        = 1,
  parameter logic [CHANNELS*WIDTH-1:0]   INIT_VALUES = '0,
  localparam int                         ADDR_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                restart,
  input  logic                mode,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic                wr_ready,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  typedef enum logic {
    MODE_LFSR  = 1'b0,
    MODE_COUNT = 1'b1
  } mode_e;

  // Feedback taps of a primitive polynomial for each supported width; bit
  // (t-1) is set for every tap t of the polynomial.
  function automatic logic [15:0] tap_table(input int w);
    case (w)
      4:       tap_table = 16'h000C;
      5:       tap_table = 16'h0014;
      6:       tap_table = 16'h0030;
      7:       tap_table = 16'h0060;
      8:       tap_table = 16'h00B8;
      9:       tap_table = 16'h0110;
      10:      tap_table = 16'h0240;
      11:      tap_table = 16'h0500;
      12:      tap_table = 16'h0829;
      13:      tap_table = 16'h100D;
      14:      tap_table = 16'h2015;
      15:      tap_table = 16'h6000;
      16:      tap_table = 16'hD008;
      default: tap_table = 16'h0000;
    endcase
  endfunction

  // Rotate left by s places; the doubled word avoids a shift by WIDTH when
  // s is zero.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int s);
    logic [2*WIDTH-1:0] d;
    d = {x, x} << s;
    return d[2*WIDTH-1:WIDTH];
  endfunction

  localparam logic [15:0]       TAPS16 = tap_table(WIDTH);
  localparam logic [WIDTH-1:0]  TAPS   = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0]  SEED_V = WIDTH'(SEED);
  // Last phase of the period, P-1 = 2^WIDTH-2.
  localparam logic [WIDTH-1:0]  P_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [WIDTH-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                ps_q, ps_d;
  mode_e               amode_q, amode_d;

  logic [CHANNELS-1:0] addr_hit;
  logic                wr_fire;
  logic                boundary;
  logic [WIDTH-1:0]    lfsr_next;
  logic [WIDTH-1:0]    ref_val [CHANNELS];

  // Address decode. An out-of-range address hits no channel, so it always
  // reads as ready and any write to it is silently dropped.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      addr_hit[k] = (wr_addr == ADDR_W'(k));
    end
  end

  assign wr_ready  = ~|(addr_hit & pending_q);
  assign wr_fire   = wr_en & wr_ready;
  assign boundary  = en & (phase_q == P_LAST);
  assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

  // Comparison reference per channel. The LFSR never holds zero, so the
  // rotated value minus one spans 0..P-1 exactly once per period; the
  // rotation decorrelates the channels from each other.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (amode_q == MODE_COUNT) begin
        ref_val[k] = phase_q;
      end else begin
        ref_val[k] = rotl(lfsr_q, k % WIDTH) - WIDTH'(1);
      end
    end
  end

  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    lfsr_d    = lfsr_q;
    phase_d   = phase_q;
    out_d     = out_q;
    ps_d      = ps_q;
    amode_d   = amode_q;
    pending_d = pending_q;
    active_d  = active_q;
    shadow_d  = shadow_q;

    if (restart) begin
      lfsr_d  = SEED_V;
      phase_d = '0;
      out_d   = '0;
      ps_d    = 1'b0;
      amode_d = mode_e'(mode);
      // Pending values and a write arriving on this very edge commit at once.
      for (int k = 0; k < CHANNELS; k++) begin
        if (pending_q[k]) active_d[k] = shadow_q[k];
        if (wr_fire && addr_hit[k]) active_d[k] = wr_data;
      end
      pending_d = '0;
    end else begin
      if (en) begin
        for (int k = 0; k < CHANNELS; k++) begin
          out_d[k] = (ref_val[k] < active_q[k]);
        end
        ps_d    = (phase_q == '0);
        lfsr_d  = lfsr_next;
        phase_d = boundary ? '0 : phase_q + WIDTH'(1);
      end

      if (boundary) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (pending_q[k]) active_d[k] = shadow_q[k];
        end
        pending_d = '0;
        amode_d   = mode_e'(mode);
      end

      // Placed after the commit so a write on the boundary edge waits for
      // the following boundary.
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_fire && addr_hit[k]) begin
          shadow_d[k]  = wr_data;
          pending_d[k] = 1'b1;
        end
      end
    end
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lfsr_q    <= SEED_V;
      phase_q   <= '0;
      pending_q <= '0;
      out_q     <= '0;
      ps_q      <= 1'b0;
      amode_q   <= MODE_LFSR;
      // NOTE: the value arrays are small register banks, not RAM, so they are
      // reset; this keeps a reset mid-period from leaking stale shadows.
      for (int k = 0; k < CHANNELS; k++) begin
        active_q[k] <= INIT_VALUES[k*WIDTH +: WIDTH];
        shadow_q[k] <= '0;
      end
    end else begin
      lfsr_q    <= lfsr_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      ps_q      <= ps_d;
      amode_q   <= amode_d;
      for (int k = 0; k < CHANNELS; k++) begin
        active_q[k] <= active_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign out          = out_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_sc_const_bank.sv
// -----------------------------------------------------------------------------
// tb_sc_const_bank
//
// Directed bench for sc_const_bank at default parameters (4 channels, 9 bits,
// P = 511). A cycle model of the commit/phase behaviour pushes the expected
// out/period_start for every edge into a scoreboard queue; the entry is popped
// and compared one time unit after the edge. Channels running in LFSR mode
// with a fractional value are not predicted bit by bit; their ones count over
// each full period is checked instead.
// -----------------------------------------------------------------------------
module tb_sc_const_bank;

  localparam int CH = 4;
  localparam int W  = 9;
  localparam int P  = 511;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          en = 1'b0;
  logic          restart = 1'b0;
  logic          mode = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready;
  logic [CH-1:0] out;
  logic          period_start;

  always #5 clk = ~clk;

  sc_const_bank #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .SEED        (1),
    .INIT_VALUES ('0)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .en           (en),
    .restart      (restart),
    .mode         (mode),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .out          (out),
    .period_start (period_start)
  );

  typedef struct packed {
    logic [CH-1:0] out_exp;
    logic [CH-1:0] out_chk;   // 1 = bit is predicted exactly
    logic          ps;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_phase;
  int            m_active  [CH];
  int            m_shadow  [CH];
  bit            m_pending [CH];
  bit            m_amode;
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_chk;
  logic          m_ps;
  int            ones [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_amode = 1'b0;
    m_out   = '0;
    m_chk   = '1;
    m_ps    = 1'b0;
    for (int k = 0; k < CH; k++) begin
      m_active[k]  = 0;   // INIT_VALUES is all zero
      m_shadow[k]  = 0;
      m_pending[k] = 1'b0;
    end
  endtask

  task automatic clear_ones();
    for (int k = 0; k < CH; k++) ones[k] = 0;
  endtask

  task automatic commit_pending();
    for (int k = 0; k < CH; k++) begin
      if (m_pending[k]) m_active[k] = m_shadow[k];
      m_pending[k] = 1'b0;
    end
  endtask

  // One clock edge: drive inputs, check wr_ready, advance the model, push the
  // expectation, then pop and compare after the edge.
  task automatic step(input bit s_en, input bit s_rst, input bit s_mode,
                      input bit s_wr, input int s_addr, input int s_data);
    bit   acc;
    exp_t e;
    exp_t got;
    en      = s_en;
    restart = s_rst;
    mode    = s_mode;
    wr_en   = s_wr;
    wr_addr = 2'(s_addr);
    wr_data = W'(s_data);
    #1;
    check("wr_ready", 32'(wr_ready), 32'(!m_pending[s_addr]));
    acc = s_wr && !m_pending[s_addr];
    @(posedge clk);

    if (s_rst) begin
      commit_pending();
      if (acc) m_active[s_addr] = s_data;
      m_amode = s_mode;
      m_phase = 0;
      m_out   = '0;
      m_chk   = '1;
      m_ps    = 1'b0;
    end else begin
      if (s_en) begin
        m_ps = (m_phase == 0);
        for (int k = 0; k < CH; k++) begin
          if (m_amode) begin
            m_out[k] = (m_phase < m_active[k]);
            m_chk[k] = 1'b1;
          end else if (m_active[k] == 0) begin
            m_out[k] = 1'b0;
            m_chk[k] = 1'b1;
          end else if (m_active[k] == P) begin
            m_out[k] = 1'b1;
            m_chk[k] = 1'b1;
          end else begin
            m_out[k] = 1'b0;
            m_chk[k] = 1'b0;
          end
        end
        if (m_phase == P - 1) begin
          commit_pending();
          m_amode = s_mode;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      if (acc) begin
        m_shadow[s_addr]  = s_data;
        m_pending[s_addr] = 1'b1;
      end
    end

    e.out_exp = m_out;
    e.out_chk = m_chk;
    e.ps      = m_ps;
    sb.push_back(e);

    #1;
    got = sb.pop_front();
    check("out", 32'(out & got.out_chk), 32'(got.out_exp & got.out_chk));
    check("period_start", 32'(period_start), 32'(got.ps));
    if (s_en && !s_rst) begin
      for (int k = 0; k < CH; k++) ones[k] += int'(out[k]);
    end
    wr_en = 1'b0;
  endtask

  task automatic run(input int n, input bit s_mode);
    repeat (n) step(1'b1, 1'b0, s_mode, 1'b0, 0, 0);
  endtask

  // Advance until the next enabled edge will be the first of a period.
  task automatic run_to_period_start(input bit s_mode);
    for (int i = 0; i < P + 2 && m_phase != 0; i++) step(1'b1, 1'b0, s_mode, 1'b0, 0, 0);
  endtask

  // One full period from period_start; optional freeze of en inside it.
  task automatic measure(input int ch, input int req, input bit s_mode,
                         input int freeze_at, input int freeze_len);
    clear_ones();
    for (int i = 0; i < P; i++) begin
      if (i == freeze_at) repeat (freeze_len) step(1'b0, 1'b0, s_mode, 1'b0, 0, 0);
      step(1'b1, 1'b0, s_mode, 1'b0, 0, 0);
    end
    check($sformatf("ones_ch%0d", ch), 32'(ones[ch]), 32'(req));
  endtask

  initial begin
    model_reset();
    clear_ones();

    // Reset state
    #12;
    check("reset_out", 32'(out), 32'(0));
    check("reset_period_start", 32'(period_start), 32'(0));
    check("reset_wr_ready", 32'(wr_ready), 32'(1));
    @(negedge clk);
    n_rst = 1'b1;

    // Zero values: all-zero output, period_start on edges 1, 512, 1023
    run(2 * P + 1, 1'b0);
    for (int k = 0; k < CH; k++) check($sformatf("zero_ones_ch%0d", k), 32'(ones[k]), 32'(0));

    // Mid-period write ch0=256, LFSR mode
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 256);
    run_to_period_start(1'b0);
    measure(0, 256, 1'b0, -1, 0);
    measure(0, 256, 1'b0, -1, 0);

    // Counter mode and new values requested mid-period
    run(40, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1, 100);
    step(1'b1, 1'b0, 1'b1, 1'b1, 2, 511);
    step(1'b1, 1'b0, 1'b1, 1'b1, 3, 0);
    run_to_period_start(1'b1);

    // Period A in counter mode; write ch3 on the boundary edge
    clear_ones();
    run(P - 1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 3, 5);
    check("A_ones_ch0", 32'(ones[0]), 32'(256));
    check("A_ones_ch1", 32'(ones[1]), 32'(100));
    check("A_ones_ch2", 32'(ones[2]), 32'(511));
    check("A_ones_ch3", 32'(ones[3]), 32'(0));

    // Period B: ch3 still pending, second write refused
    step(1'b1, 1'b0, 1'b1, 1'b1, 3, 9);
    run_to_period_start(1'b1);

    // Period C: ch3=5 live; mode 0 requested, applied at its end
    measure(3, 5, 1'b0, -1, 0);

    // Period D in LFSR mode
    clear_ones();
    run(P, 1'b0);
    check("D_ones_ch0", 32'(ones[0]), 32'(256));
    check("D_ones_ch1", 32'(ones[1]), 32'(100));
    check("D_ones_ch2", 32'(ones[2]), 32'(511));
    check("D_ones_ch3", 32'(ones[3]), 32'(5));

    // Back-to-back writes to ch0, then restart with a simultaneous write
    run(30, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 50);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 77);
    run(10, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1, 30);
    measure(0, 50, 1'b1, -1, 0);
    check("restart_ones_ch1", 32'(ones[1]), 32'(30));

    // en low for 20 cycles inside a period
    measure(0, 50, 1'b1, 200, 20);

    // Writes still accepted while en is low, then reset discards them
    run(100, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 2, 10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    run(50, 1'b1);
    #1;
    n_rst = 1'b0;
    wr_addr = 2'd2;
    #1;
    check("midreset_out", 32'(out), 32'(0));
    check("midreset_period_start", 32'(period_start), 32'(0));
    check("midreset_wr_ready", 32'(wr_ready), 32'(1));
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    run(P, 1'b0);
    clear_ones();
    run(P, 1'b0);
    for (int k = 0; k < CH; k++) check($sformatf("post_reset_ones_ch%0d", k), 32'(ones[k]), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_const_bank.md
SC_CONST_BANK -- requirements
Module: sc_const_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of bitstream channels (legal 1..16).
REQ-002 The block SHALL have parameter WIDTH, default 9, comparator/generator width (legal 4..16); period P = 2^WIDTH-1.
REQ-003 The block SHALL have parameter SEED, default 1, nonzero LFSR restart value.
REQ-004 The block SHALL have parameter INIT_VALUES, default 0, CHANNELS*WIDTH-bit packed reset values, with channel k at bits [k*WIDTH +: WIDTH].
REQ-005 The block SHALL provide ports:
  clk  in  1  clock
  n_rst  in  1  reset, asynchronous, active-low
  en  in  1  advance generator; low = hold
  restart  in  1  synchronous period restart
  mode  in  1  0 = LFSR (random), 1 = counter (unary)
  wr_en  in  1  value write request
  wr_addr  in  max(1,$clog2(CHANNELS))  target channel
  wr_data  in  WIDTH  new value = ones per period
  wr_ready  out  1  write accept
  out  out  CHANNELS  registered bitstreams
  period_start  out  1  high on first output bit of each period

Function
REQ-006 The generator SHALL be a maximal-length Fibonacci LFSR of WIDTH bits (fixed tap table per WIDTH), never zero, period P.
REQ-007 The phase counter SHALL run 0..P-1 and wrap to 0, advancing only on edges with en=1.
REQ-008 In LFSR mode, channel k SHALL compare r_k = rotl(lfsr, k mod WIDTH) - 1; in counter mode, every channel SHALL compare r = phase.
REQ-009 On each enabled edge: out[k] <= (r_k < active_value[k]); period_start <= (phase == 0); then LFSR and phase advance.
REQ-010 Each channel SHALL output exactly active_value ones per P-cycle period; value P SHALL yield constant 1 and value 0 constant 0.
REQ-011 wr_ready SHALL equal ~pending[wr_addr], or 1 when wr_addr >= CHANNELS.
REQ-012 A write with wr_en & wr_ready SHALL store wr_data in shadow[wr_addr] and set pending[wr_addr].
REQ-013 A write to an out-of-range wr_addr SHALL be discarded, and a write with wr_ready=0 SHALL be ignored.
REQ-014 On the enabled edge where phase == P-1 (boundary), all pending shadows SHALL copy to active_value, pending SHALL clear, and active_mode SHALL be loaded from mode.
REQ-015 A write accepted on the boundary edge SHALL remain pending until the next boundary.
REQ-016 mode SHALL affect outputs only via active_mode; changes mid-period SHALL have no effect until the boundary.
REQ-017 restart=1 SHALL take priority over en.
REQ-018 On a restart edge: LFSR <= SEED, phase <= 0, pending shadows and any simultaneous accepted write commit immediately, active_mode <= mode, out <= 0, period_start <= 0.
REQ-019 en=0 without restart SHALL hold LFSR, phase, out and period_start, and SHALL still accept writes.

Reset
REQ-020 On n_rst low, the block SHALL asynchronously set LFSR = SEED, phase = 0, active_value = INIT_VALUES, shadows = 0, pending = 0, active_mode = 0, out = 0, period_start = 0.
REQ-021 The first enabled edge after reset release SHALL produce period_start = 1.
REQ-022 Reset asserted mid-period SHALL discard pending writes.

Verification
REQ-023 Defaults, en=1 after reset -> out=4'b0000 for 1022 cycles; period_start high on edges 1, 512, 1023.
REQ-024 Mid-period write ch0=256 -> out[0] stays 0 to the boundary, then exactly 256 ones in every 511-cycle window starting at period_start.
REQ-025 Counter mode set mid-period with ch1=100 -> from the next boundary, out[1]=1 for 100 cycles after period_start, then 0 for 411.
REQ-026 ch2=511 and ch3=0 -> out[2] constantly 1 and out[3] constantly 0 after the boundary.
REQ-027 Write ch0 then an immediate second write to ch0 -> wr_ready=0 and the second write is ignored; restart mid-period -> next edge period_start=0, then the following enabled edge gives period_start=1 with the first value committed.
REQ-028 en low for 20 cycles -> out/period_start frozen and ones-count unchanged; n_rst pulse mid-period -> all outputs 0 and INIT_VALUES restored.
